muldiv_controller: RTL

Sequences an iterative 32-cycle multiply/divide unit and its HI/LO registers for the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the Execute stage and runs them while the pipeline continues. It raises a stall toward the hazard logic when a dependent HI/LO access, or a second mul/div, reaches Decode while the unit is busy. It also handles MTHI/MTLO writes, flush aborts and divide-by-zero.

---
 rtl/mips_muldiv_pkg.sv | 27 ++
 rtl/muldiv_controller_chk.sv | 20 ++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents: default operand width, operation encoding, FSM state encoding
// and a helper that tells signed operations from unsigned ones.
package mips_muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    // FSM encoding kept as plain constants so older tools and netlists
    // can match on the raw two-bit value.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // MULT and DIV work on magnitudes; MULTU and DIVU take operands raw.
    function automatic logic op_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_controller_chk.sv
// Protocol checks for the multiply/divide controller.
// Ports: clk, reset, start, busy, mthi, mtlo (all observed, none driven).
// A new start while busy, or a start sharing a cycle with MTHI/MTLO, means
// the hazard logic upstream let an illegal sequence through.
module muldiv_controller_chk (
    input logic clk,
    input logic reset,
    input logic start,
    input logic busy,
    input logic mthi,
    input logic mtlo
);

    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (reset) !(start && busy));

    a_no_start_with_mt: assert property (
        @(posedge clk) disable iff (reset) !(start && (mthi || mtlo)));

endmodule

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
// Ports:
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc      : 2*WIDTH accumulator {upper, lower}
//   divisor  : multiplier magnitude (mul) or divisor magnitude (div)
//   acc_next : accumulator after one iteration
// Multiply: upper half accumulates, lower half holds the remaining multiplier
// bits; the whole thing shifts right by one each step.
// Divide: upper half is the partial remainder, lower half shifts the dividend
// out at the top and the quotient bits in at the bottom.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    // Single iteration: add-and-shift for multiply, trial subtract for divide.
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, divisor} : {(WIDTH+1){1'b0}});
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        diff      = rem_shift - {1'b0, divisor};
        if (is_div) begin
            // diff MSB clear means no borrow: the divisor fits, keep the difference.
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// Sequencer for the iterative 32-cycle multiply/divide unit and HI/LO.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, op, src_a/b    : mul/div issue from Execute (op: MULT/MULTU/DIV/DIVU)
//   flush                 : aborts an accept or a running operation
//   mfhi_d/mflo_d/muldiv_d: Decode-stage HI/LO consumers, used for stall
//   mthi, mtlo, wdata     : direct HI/LO writes from Execute
//   hi, lo                : architectural HI/LO registers
//   busy, stall, done     : in-flight flag, hazard stall, completion pulse
//   div_zero              : sticky flag for the last divide by zero
module muldiv_controller
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             mfhi_d,
    input  logic             mflo_d,
    input  logic             muldiv_d,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNTW-1:0]    count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   divisor;
    logic               is_div;
    logic               neg_x;     // product / quotient sign
    logic               neg_a;     // remainder sign (follows the dividend)
    logic               dz;        // current divide has a zero divisor

    logic               sgn;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (state == ST_DIV),
        .acc      (acc),
        .divisor  (divisor),
        .acc_next (acc_next)
    );

    muldiv_controller_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .mthi  (mthi),
        .mtlo  (mtlo)
    );

    // Operand magnitudes at issue and sign-corrected results at fix-up.
    always_comb begin
        sgn      = op_signed(op);
        mag_a    = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
        mag_b    = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;
        prod_fix = neg_x ? -acc : acc;
        quo_fix  = neg_x ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Status decode toward the pipeline hazard logic.
    always_comb begin
        busy  = (state != ST_IDLE);
        stall = busy && (mfhi_d || mflo_d || muldiv_d);
    end

    // FSM, iteration counter, datapath registers and HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= {CNTW{1'b0}};
            acc      <= {(2*WIDTH){1'b0}};
            divisor  <= {WIDTH{1'b0}};
            is_div   <= 1'b0;
            neg_x    <= 1'b0;
            neg_a    <= 1'b0;
            dz       <= 1'b0;
            hi       <= {WIDTH{1'b0}};
            lo       <= {WIDTH{1'b0}};
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // Abort wins over issue and over the final write.
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            dz       <= op[1] && (src_b == {WIDTH{1'b0}});
                            // A zero-divisor divide returns the raw dividend in HI,
                            // so park it in the upper half for the next edge.
                            acc      <= (op[1] && (src_b == {WIDTH{1'b0}}))
                                      ? {src_a, mag_a} : {{WIDTH{1'b0}}, mag_a};
                            divisor  <= mag_b;
                            is_div   <= op[1];
                            neg_x    <= sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            neg_a    <= sgn && src_a[WIDTH-1];
                            count    <= {CNTW{1'b0}};
                            div_zero <= 1'b0;
                            state    <= op[1] ? ST_DIV : ST_MUL;
                        end else begin
                            if (mthi) hi <= wdata;
                            if (mtlo) lo <= wdata;
                        end
                    end
                    ST_MUL: begin
                        acc   <= acc_next;
                        count <= count + {{(CNTW-1){1'b0}}, 1'b1};
                        if (count == LAST) state <= ST_FIX;
                    end
                    ST_DIV: begin
                        if (dz) begin
                            hi       <= acc[2*WIDTH-1:WIDTH];
                            lo       <= {WIDTH{1'b1}};
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            acc   <= acc_next;
                            count <= count + {{(CNTW-1){1'b0}}, 1'b1};
                            if (count == LAST) state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
